// File: rtl/mux2to1_if.sv
// Select bus for mux2to1: the select, both data inputs, and the combinational
// and registered results. clk/reset stay outside as plain ports.
`timescale 1ns/1ps
interface mux2to1_if #(
  parameter int WIDTH = 1
);
  logic             sel1;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;

  // Driver side: presents select and data, observes both results.
  modport master (
    output sel1, in0, in1,
    input  out, out_q
  );

  // Mux side: consumes select and data, produces both results.
  modport slave (
    input  sel1, in0, in1,
    output out, out_q
  );
endinterface

// File: rtl/mux2to1.sv
// mux2to1: bitwise 2:1 selector with a combinational output and a registered
// copy. Each bit is an independent lane; no cross-bit logic. WIDTH 1..64.
`timescale 1ns/1ps

// One bit of the selector. The AND-OR form is kept gate-shaped; the extra
// consensus term (d0 & d1) is logically redundant but makes an unknown select
// resolve to the data value whenever both data bits agree.
module mux2to1_lane (
  input  logic sel1,
  input  logic d0,
  input  logic d1,
  output logic y
);
  // Combinational select with consensus term.
  assign y = (d1 & sel1) | (d0 & ~sel1) | (d0 & d1);
endmodule

module mux2to1 #(
  parameter int WIDTH = 1
) (
  input  logic       clk,
  input  logic       reset,
  mux2to1_if.slave   bus
);
  logic [WIDTH-1:0] sel_out;
  logic [WIDTH-1:0] out_q_r;

  // One lane per bit; lanes share only the select.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    mux2to1_lane u_lane (
      .sel1 (bus.sel1),
      .d0   (bus.in0[i]),
      .d1   (bus.in1[i]),
      .y    (sel_out[i])
    );
  end

  assign bus.out   = sel_out;
  assign bus.out_q = out_q_r;

  // Registered copy of the selected value; reset clears only this register.
  always_ff @(posedge clk) begin
    if (reset) out_q_r <= '0;
    else       out_q_r <= sel_out;
  end
endmodule

// File: tb/tb_mux2to1.sv
// Scoreboard bench for mux2to1 at widths 1, 7 and 64. Stimulus pushes
// expected values into a queue and fires a strobe 150 ps after driving;
// the monitor drains the queue and compares against the live DUT outputs.
`timescale 1ns/1ps
module tb_mux2to1;
  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  mux2to1_if #(.WIDTH(1))  b1();
  mux2to1_if #(.WIDTH(7))  b7();
  mux2to1_if #(.WIDTH(64)) b64();

  mux2to1 #(.WIDTH(1))  u_w1  (.clk(clk), .reset(reset), .bus(b1));
  mux2to1 #(.WIDTH(7))  u_w7  (.clk(clk), .reset(reset), .bus(b7));
  mux2to1 #(.WIDTH(64)) u_w64 (.clk(clk), .reset(reset), .bus(b64));

  typedef struct {
    int          dut;   // 0: width 1, 1: width 7, 2: width 64
    bit          regp;  // 1: check out_q, 0: check out
    logic [63:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  event chk;

  task automatic expect_val(input int dut, input bit regp, input logic [63:0] exp,
                            input string name);
    exp_t e;
    e.dut = dut; e.regp = regp; e.exp = exp; e.name = name;
    q.push_back(e);
  endtask

  // Let the combinational path settle for the 150 ps budget, then sample.
  task automatic strobe();
    #0.15;
    -> chk;
    #0.05;
  endtask

  // Monitor: compare every queued expectation when the strobe fires.
  initial begin
    forever begin
      @(chk);
      while (q.size() > 0) begin
        exp_t        e;
        logic [63:0] act;
        e = q.pop_front();
        case (e.dut)
          0:       act = e.regp ? 64'(b1.out_q)  : 64'(b1.out);
          1:       act = e.regp ? 64'(b7.out_q)  : 64'(b7.out);
          default: act = e.regp ? b64.out_q      : b64.out;
        endcase
        total++;
        if (act !== e.exp) begin
          bad++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  tt;
    logic [2:0]  v;
    logic [6:0]  r0, r1;
    logic [63:0] ones;

    b1.sel1 = 1'b0;  b1.in0 = '0;  b1.in1 = '0;
    b7.sel1 = 1'b0;  b7.in0 = '0;  b7.in1 = '0;
    b64.sel1 = 1'b0; b64.in0 = '0; b64.in1 = '0;

    // Reset held for two edges clears every registered output.
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    expect_val(0, 1'b1, 64'h0, "reset_q_w1");
    expect_val(1, 1'b1, 64'h0, "reset_q_w7");
    expect_val(2, 1'b1, 64'h0, "reset_q_w64");
    strobe();

    // Select 0, single bit.
    b1.in0 = 1'b1; b1.in1 = 1'b0; b1.sel1 = 1'b0;
    expect_val(0, 1'b0, 64'h1, "sel0_in0_1");
    strobe();
    b1.in0 = 1'b0;
    expect_val(0, 1'b0, 64'h0, "sel0_in0_0");
    strobe();

    // Select 1 then 0, width 7.
    b7.in0 = 7'h24; b7.in1 = 7'h01; b7.sel1 = 1'b1;
    expect_val(1, 1'b0, 64'h01, "w7_sel1");
    strobe();
    b7.sel1 = 1'b0;
    expect_val(1, 1'b0, 64'h24, "w7_sel0");
    strobe();

    // Exhaustive single bit: {sel1,in1,in0} truth table, hand-written.
    tt = 8'hCA;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      b1.sel1 = v[2]; b1.in1 = v[1]; b1.in0 = v[0];
      expect_val(0, 1'b0, 64'(tt[i]), $sformatf("tt_%0d", i));
      strobe();
    end

    // Unknown select with agreeing data resolves to the data value.
    b1.sel1 = 1'bx; b1.in0 = 1'b1; b1.in1 = 1'b1;
    expect_val(0, 1'b0, 64'h1, "selx_both1");
    strobe();
    b1.in0 = 1'b0; b1.in1 = 1'b0;
    expect_val(0, 1'b0, 64'h0, "selx_both0");
    strobe();
    b1.sel1 = 1'b0;

    // Random sweep, width 7, 10 ns apart, sel1 = iteration bit 0.
    for (int i = 0; i < 8; i++) begin
      r0 = 7'($urandom); r1 = 7'($urandom);
      b7.in0 = r0; b7.in1 = r1; b7.sel1 = i[0];
      expect_val(1, 1'b0, i[0] ? 64'(r1) : 64'(r0), $sformatf("sweep_%0d", i));
      strobe();
      #9.8;
    end

    // Width 64: toggle select, all bits must flip within the strobe window.
    ones = '1;
    b64.in0 = ones; b64.in1 = '0;
    for (int i = 0; i < 4; i++) begin
      b64.sel1 = i[0];
      expect_val(2, 1'b0, i[0] ? 64'h0 : 64'hFFFF_FFFF_FFFF_FFFF, $sformatf("w64_tog_%0d", i));
      strobe();
    end

    // Register path, width 7: reset holds out_q at 0 while out tracks inputs.
    @(posedge clk); #1;
    reset = 1'b1;
    b7.in0 = 7'h24; b7.in1 = 7'h13; b7.sel1 = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    expect_val(1, 1'b1, 64'h0,  "rst_hold_q");
    expect_val(1, 1'b0, 64'h24, "rst_hold_out0");
    strobe();
    b7.sel1 = 1'b1;
    expect_val(1, 1'b0, 64'h13, "rst_hold_out1");
    strobe();

    // Release reset with in1 = 55 selected; one edge later out_q = 55.
    reset = 1'b0; b7.in1 = 7'h55; b7.sel1 = 1'b1;
    @(posedge clk); #1;
    expect_val(1, 1'b1, 64'h55, "release_q");
    strobe();

    b7.in0 = 7'h2A; b7.sel1 = 1'b0;
    @(posedge clk); #1;
    expect_val(1, 1'b1, 64'h2A, "stream_q");
    strobe();

    // Reset mid-stream overrides data on the edge that samples it.
    reset = 1'b1; b7.in1 = 7'h7F; b7.sel1 = 1'b1;
    @(posedge clk); #1;
    expect_val(1, 1'b1, 64'h0,  "midrst_q");
    expect_val(1, 1'b0, 64'h7F, "midrst_out");
    strobe();

    reset = 1'b0;
    @(posedge clk); #1;
    expect_val(1, 1'b1, 64'h7F, "after_midrst_q");
    strobe();

    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
